pwm_peripheral: RTL and testbench

Consumes the five configuration bytes written by the SPI register stage and drives 16 output pins, each statically on, statically off, or PWM-modulated. A prescaled 8-bit timebase produces one shared PWM waveform. Its duty cycle is double-buffered so that a mid-period SPI write never produces a glitch pulse. The block sits directly downstream of the SPI peripheral and feeds the chip's output pins.

---
 rtl/pwm_peripheral_pkg.sv | 62 ++++++
 rtl/pwm_timebase.sv | 66 ++++++
 rtl/pwm_peripheral.sv | 102 ++++++++++
 tb/tb_pwm_peripheral.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_peripheral_pkg.sv
// -----------------------------------------------------------------------------
// pwm_peripheral_pkg
// Shared constants and helpers for the SPI register stage and the PWM
// peripheral: SPI register addresses, PWM resolution, the per-pin drive mode
// type and the small combinational helpers used by the output stage.
// -----------------------------------------------------------------------------
package pwm_peripheral_pkg;

    // SPI register map (addresses of the five configuration bytes)
    localparam logic [7:0] REG_EN_OUT_LO = 8'd0;
    localparam logic [7:0] REG_EN_OUT_HI = 8'd1;
    localparam logic [7:0] REG_EN_PWM_LO = 8'd2;
    localparam logic [7:0] REG_EN_PWM_HI = 8'd3;
    localparam logic [7:0] REG_DUTY      = 8'd4;

    // PWM timebase resolution and full-scale duty code
    localparam int              PWM_RES = 8;
    localparam logic [PWM_RES-1:0] PWM_MAX = 8'hFF;

    // Number of driven output pins
    localparam int NUM_PINS = 16;

    // How a single pin is driven
    typedef enum logic [1:0] {
        PIN_OFF = 2'd0,
        PIN_ON  = 2'd1,
        PIN_PWM = 2'd2
    } pin_mode_e;

    // Waveform level for a given counter value and latched duty code.
    // Full-scale is treated as a true 100 % so the pin never dips low for the
    // one counter step a plain compare would leave.
    function automatic logic pwm_level(
        input logic [PWM_RES-1:0] count,
        input logic [PWM_RES-1:0] duty
    );
        logic level;
        if (duty == PWM_MAX) begin
            level = 1'b1;
        end else begin
            level = (count < duty);
        end
        return level;
    endfunction

    // Output enable dominates; the PWM select only matters for enabled pins.
    function automatic pin_mode_e pin_mode(
        input logic en_out,
        input logic en_pwm
    );
        pin_mode_e mode;
        if (!en_out) begin
            mode = PIN_OFF;
        end else if (!en_pwm) begin
            mode = PIN_ON;
        end else begin
            mode = PIN_PWM;
        end
        return mode;
    endfunction

endpackage : pwm_peripheral_pkg

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Prescaled 8-bit PWM timebase. The prescaler divides m_clk by CLK_DIV; each
// prescaler terminal cycle (tick) advances the 8-bit counter, which wraps
// from 255 to 0. The wrap cycle is the tick on which the counter is 255.
//
// Ports:
//   m_clk  in   master clock
//   rst_n  in   asynchronous active-low reset
//   tick   out  high on the cycle the prescaler sits at CLK_DIV-1
//   wrap   out  high on the tick where count is 255 (last cycle of a period)
//   count  out  current PWM counter value
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic               m_clk,
    input  logic               rst_n,
    output logic               tick,
    output logic               wrap,
    output logic [PWM_RES-1:0] count
);

    // A divide-by-1 still needs a one-bit prescaler so the vector is legal;
    // it then simply sits at zero and every cycle is a tick.
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]   prescale_r;
    logic [PWM_RES-1:0] count_r;
    logic               tick_s;
    logic               wrap_s;

    // Decode tick and wrap straight from the state flops
    always_comb begin
        tick_s = (prescale_r == PRE_LAST);
        if (tick_s && (count_r == PWM_MAX)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Prescaler and counter; the counter wraps 255 -> 0 by natural overflow
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_r <= '0;
            count_r    <= '0;
        end else begin
            if (tick_s) begin
                prescale_r <= '0;
                count_r    <= count_r + 8'd1;
            end else begin
                prescale_r <= prescale_r + PRE_W'(1);
                count_r    <= count_r;
            end
        end
    end

    assign tick  = tick_s;
    assign wrap  = wrap_s;
    assign count = count_r;

endmodule : pwm_timebase

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Drives 16 output pins from the five SPI configuration bytes. Each pin is
// statically off, statically on, or follows one shared PWM waveform. The duty
// code is double-buffered into a shadow register that only reloads on the
// period wrap, so a mid-period SPI write cannot create a glitch pulse.
//
// Ports:
//   m_clk            in   master clock (only clock in the block)
//   rst_n            in   asynchronous active-low reset
//   en_reg_out_7_0   in   output enable, pins 7:0   (SPI reg 0)
//   en_reg_out_15_8  in   output enable, pins 15:8  (SPI reg 1)
//   en_reg_pwm_7_0   in   PWM select, pins 7:0      (SPI reg 2)
//   en_reg_pwm_15_8  in   PWM select, pins 15:8     (SPI reg 3)
//   pwm_duty_cycle   in   requested duty code       (SPI reg 4)
//   out              out  registered pin drive
// -----------------------------------------------------------------------------
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                m_clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out
);

    logic               tick_s;
    logic               wrap_s;
    logic [PWM_RES-1:0] count_s;
    logic [PWM_RES-1:0] duty_shadow_r;
    logic               pwm_signal_s;
    logic [NUM_PINS-1:0] en_out_s;
    logic [NUM_PINS-1:0] en_pwm_s;
    logic [NUM_PINS-1:0] out_next_s;
    logic [NUM_PINS-1:0] out_r;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .m_clk (m_clk),
        .rst_n (rst_n),
        .tick  (tick_s),
        .wrap  (wrap_s),
        .count (count_s)
    );

    // Assemble the 16-bit enable vectors from the byte-wide SPI registers
    always_comb begin
        en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    end

    // Duty shadow: reloads only on the last cycle of a period, so the value
    // present on the wrap cycle governs the whole following period. A wrap is
    // by construction also a tick; both are required to keep the load tied
    // to a timebase step.
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_r <= 8'h00;
        end else if (wrap_s && tick_s) begin
            duty_shadow_r <= pwm_duty_cycle;
        end else begin
            duty_shadow_r <= duty_shadow_r;
        end
    end

    // Shared PWM waveform from the counter and the latched duty code
    always_comb begin
        pwm_signal_s = pwm_level(count_s, duty_shadow_r);
    end

    // Per-pin output mux (enables are live, not shadowed)
    always_comb begin
        out_next_s = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (pin_mode(en_out_s[i], en_pwm_s[i]))
                PIN_OFF: out_next_s[i] = 1'b0;
                PIN_ON:  out_next_s[i] = 1'b1;
                PIN_PWM: out_next_s[i] = pwm_signal_s;
                default: out_next_s[i] = 1'b0;
            endcase
        end
    end

    // Registered pin drive; reset forces every pin low immediately
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
        end else begin
            out_r <= out_next_s;
        end
    end

    assign out = out_r;

endmodule : pwm_peripheral

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
// Self-checking bench for pwm_peripheral with CLK_DIV = 2 (512-cycle period).
// A reference model derives the expected pin drive from elapsed cycles since
// reset: counter = (t / CLK_DIV) mod 256, and the duty in force for a period
// is whatever duty input was present on the last cycle of the previous
// period (zero for the first period after reset).
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        m_clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;

    int          n_checks;
    int          n_fail;

    // reference model state
    int          t;        // cycles elapsed since reset release
    logic [7:0]  shadow;   // duty governing the current period

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .m_clk           (m_clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out)
    );

    initial m_clk = 1'b0;
    always #5 m_clk = ~m_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Expected pin drive for cycle tc given the duty in force and the enables
    function automatic logic [15:0] model_out(input int tc, input logic [7:0] sh,
                                              input logic [15:0] eo, input logic [15:0] ep);
        int   cnt;
        logic level;
        cnt   = (tc / CLK_DIV) % 256;
        level = (sh == 8'hFF) || (cnt < int'(sh));
        return eo & (~ep | {16{level}});
    endfunction

    // Advance one clock and compare out against the model
    task automatic step();
        logic [15:0] exp;
        logic [7:0]  nsh;
        exp = model_out(t, shadow, {en_reg_out_15_8, en_reg_out_7_0},
                        {en_reg_pwm_15_8, en_reg_pwm_7_0});
        nsh = shadow;
        if ((t % PERIOD) == PERIOD - 1) nsh = pwm_duty_cycle;
        @(posedge m_clk);
        #1;
        t++;
        shadow = nsh;
        check_value("out", {16'h0, out}, {16'h0, exp});
    endtask

    // Step until the next period boundary (at least one step)
    task automatic align();
        do step(); while ((t % PERIOD) != 0);
    endtask

    // Step n cycles and count how many had out[0] high
    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (out[0]) hi++;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_reset", {16'h0, out}, 32'h0);
        repeat (3) begin
            @(posedge m_clk);
            #1;
            check_value("reset_hold", {16'h0, out}, 32'h0);
        end
        rst_n  = 1'b1;
        t      = 0;
        shadow = 8'h00;
    endtask

    initial begin
        int hi;
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        shadow   = 8'h00;

        // 1. reset values with every input at 0xFF
        rst_n           = 1'b0;
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'hFF;
        pwm_duty_cycle  = 8'hFF;
        repeat (3) begin
            @(posedge m_clk);
            #1;
            check_value("reset_out", {16'h0, out}, 32'h0);
        end
        rst_n = 1'b1;
        count_high(PERIOD, hi);
        check_value("first_period_low", hi, 32'd0);

        // 2. static enables
        en_reg_pwm_7_0  = 8'h00;
        en_reg_pwm_15_8 = 8'h00;
        step();
        check_value("static_all_on", {16'h0, out}, 32'hFFFF);
        en_reg_out_7_0  = 8'hF0;
        en_reg_out_15_8 = 8'h00;
        step();
        check_value("static_00f0", {16'h0, out}, 32'h00F0);

        // 3. 50 % duty on pin 0
        pwm_duty_cycle  = 8'h80;
        en_reg_out_7_0  = 8'h01;
        en_reg_pwm_7_0  = 8'h01;
        align();
        count_high(PERIOD, hi);
        check_value("duty50_p1", hi, 32'd256);
        count_high(PERIOD, hi);
        check_value("duty50_p2", hi, 32'd256);

        // 4. duty endpoints
        pwm_duty_cycle = 8'h00;
        align();
        count_high(PERIOD, hi);
        check_value("duty00", hi, 32'd0);
        pwm_duty_cycle = 8'hFF;
        align();
        count_high(PERIOD, hi);
        check_value("dutyff_p1", hi, 32'd512);
        count_high(PERIOD, hi);
        check_value("dutyff_p2", hi, 32'd512);

        // 5. mid-period duty write must not disturb the running period
        pwm_duty_cycle = 8'h40;
        align();
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == 2 * 8'h20) pwm_duty_cycle = 8'hC0;
            step();
            if (out[0]) hi++;
        end
        check_value("glitch_free_cur", hi, 32'd128);
        count_high(PERIOD, hi);
        check_value("glitch_free_next", hi, 32'd384);

        // 6. reset in the middle of a high pulse
        pwm_duty_cycle = 8'h80;
        align();
        repeat (2 * 8'h10) step();
        check_value("pre_reset_high", {31'h0, out[0]}, 32'd1);
        pulse_reset();
        count_high(PERIOD, hi);
        check_value("post_reset_low", hi, 32'd0);
        count_high(PERIOD, hi);
        check_value("post_reset_duty50", hi, 32'd256);

        // 7. randomized enables and duty writes against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                en_reg_out_7_0  = 8'($urandom);
                en_reg_out_15_8 = 8'($urandom);
                en_reg_pwm_7_0  = 8'($urandom);
                en_reg_pwm_15_8 = 8'($urandom);
            end
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pwm_duty_cycle = 8'h00;
                    1:       pwm_duty_cycle = 8'hFF;
                    default: pwm_duty_cycle = 8'($urandom);
                endcase
            end
            if (k == 2500) pulse_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pwm_peripheral
